id_scoreboard: RTL and testbench
================================

// Module: id_scoreboard
// PURPOSE
//  Register scoreboard and issue controller for the ID stage of the bluex pipeline.
//  Tracks GPRs with outstanding long-latency writes (load, MDU) and holds the ID instruction
//  until its source and destination registers are free (RAW and WAW interlock).
//  Consumes the destination register select produced by the ID aux decode (rt/rd mux).
//  Write-back returns clear the pending state.
// PARAMETERS
//  ADR_W    `GPR_ADR (5)  GPR address width; the scoreboard holds 2**ADR_W entries
//  MAX_OUT  4             max outstanding long-latency writes (1..15)
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous reset, active-high
//  id_valid     in   1        ID holds a valid instruction
//  id_rs        in   ADR_W    source register rs
//  id_rt        in   ADR_W    source register rt
//  id_use_rs    in   1        instruction reads rs
//  id_use_rt    in   1        instruction reads rt
//  id_wr_en     in   1        instruction writes a GPR
//  id_addr_reg  in   ADR_W    destination GPR (rd or rt, already selected)
//  id_long      in   1        destination is written by a long-latency unit
//  id_ready     out  1        instruction may issue this cycle
//  wb_valid     in   1        long-latency write-back completes this cycle
//  wb_addr      in   ADR_W    register written by that write-back
//  pend_mask    out  2**ADR_W pending bitmap, bit n = GPR n
//  pend_cnt     out  4        number of outstanding long writes
//  sb_err       out  1        sticky: write-back to a non-pending register
// BEHAVIOUR
//  - Reset (async): pend_mask=0, pend_cnt=0, sb_err=0. id_ready is combinational and is 0 while
//    rst is high.
//  - hazard = (id_use_rs & pend[id_rs]) | (id_use_rt & pend[id_rt]) | (id_wr_en & pend[id_addr_reg]).
//  - full = (pend_cnt == MAX_OUT).
//  - id_ready = id_valid & ~hazard & ~(id_wr_en & id_long & full).
//  - Issue fires when id_ready=1.
//    - If id_wr_en & id_long & id_addr_reg!=0: pend[id_addr_reg] is set at the next edge and
//      pend_cnt increments.
//    - Short-latency writes (id_long=0) do not touch the scoreboard; forwarding covers them.
//  - GPR 0 is never pending. Issues targeting 0 do not set a bit or count, and a use of GPR 0
//    never stalls.
//  - Write-back with wb_valid=1:
//    - pend[wb_addr]=1: the bit clears at the next edge and pend_cnt decrements.
//    - pend[wb_addr]=0 or wb_addr=0: no state change, and sb_err sets at the next edge.
//  - Simultaneous issue (set) and write-back (clear) in one cycle:
//    - Both apply. Net pend_cnt change is 0.
//    - Different registers: independent.
//    - Same register: impossible, because the WAW check blocks the issue (without WB_BYPASS_EN).
//  - The hazard check uses the registered pend. A cleared bit unblocks ID one cycle after
//    wb_valid.
//  - Stall latency: at least 1 cycle. An instruction stays in ID with id_ready=0 until its
//    hazards clear. The block holds no instruction state.
//  - pend_cnt never exceeds MAX_OUT and never wraps below 0. A decrement at 0 is impossible,
//    since it would be an error write-back.
//  - Reset mid-operation drops all pending state. Later write-backs for lost entries raise sb_err.
// CONFIGURATION
//  BLUEX_SB_WB_BYPASS_EN defined:
//   - The hazard and full checks use the next-state view: pend & ~wb_clear, and a count that
//     includes this cycle's write-back.
//   - A dependent instruction issues in the same cycle as wb_valid.
//   - On an issue to the same register as wb_addr: the clear applies first, then the set, so the
//     bit ends 1 and the count is unchanged.
//  Undefined: checks use registered state only (1-cycle bubble after write-back).
// TESTING
//  1 rst=1 then 0 -> pend_mask=0, pend_cnt=0, sb_err=0; id_valid=1, no hazards -> id_ready=1.
//  2 issue long write r8; next cycle id_use_rs=1, id_rs=8 -> id_ready=0. wb_valid wb_addr=8 ->
//    id_ready=1 one cycle later (same cycle with BLUEX_SB_WB_BYPASS_EN).
//  3 issue long writes r1..r4 (MAX_OUT=4) -> pend_cnt=4; a 5th long write to r5 -> id_ready=0.
//    Short write to r5 -> id_ready=1. After wb r2 -> long r5 issues, pend_cnt=4.
//  4 long write to r0 -> pend_mask=0, pend_cnt=0; id_use_rt=1, id_rt=0 -> never stalls.
//  5 wb_valid wb_addr=9 with r9 not pending -> sb_err=1, sticky until rst; pend_cnt unchanged.
//  6 pend r3,r7, assert rst mid-stream -> immediately pend_mask=0, pend_cnt=0, id_ready=0;
//    after release -> r3 user issues.

Source files
------------

// File: rtl/id_scoreboard.sv
// Register scoreboard and issue interlock for the bluex ID stage (RAW/WAW on long-latency writes).
// Optional same-cycle write-back bypass of the hazard/full checks: define BLUEX_SB_WB_BYPASS_EN.
module id_scoreboard #(
  parameter int unsigned ADR_W   = 5,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [ADR_W-1:0]        id_rs,
  input  logic [ADR_W-1:0]        id_rt,
  input  logic                    id_use_rs,
  input  logic                    id_use_rt,
  input  logic                    id_wr_en,
  input  logic [ADR_W-1:0]        id_addr_reg,
  input  logic                    id_long,
  output logic                    id_ready,
  input  logic                    wb_valid,
  input  logic [ADR_W-1:0]        wb_addr,
  output logic [(1<<ADR_W)-1:0]   pend_mask,
  output logic [3:0]              pend_cnt,
  output logic                    sb_err
);
  localparam int unsigned NREG  = 1 << ADR_W;
  localparam int unsigned CNT_W = 4;

  logic             wb_hit;
  logic             issue_set;
  logic             hazard;
  logic             full;
  logic [NREG-1:0]  wb_clr;
  logic [NREG-1:0]  set_vec;
  logic [NREG-1:0]  pend_view;
  logic [CNT_W-1:0] cnt_view;

  // A write-back only retires a register that is actually pending; GPR 0 never is.
  always_comb begin
    wb_hit = wb_valid && (wb_addr != '0) && pend_mask[wb_addr];
    wb_clr = '0;
    if (wb_hit) wb_clr[wb_addr] = 1'b1;
  end

`ifdef BLUEX_SB_WB_BYPASS_EN
  assign pend_view = pend_mask & ~wb_clr;
  assign cnt_view  = pend_cnt - CNT_W'(wb_hit);
`else
  assign pend_view = pend_mask;
  assign cnt_view  = pend_cnt;
`endif

  always_comb begin
    hazard    = (id_use_rs && (id_rs != '0) && pend_view[id_rs]) ||
                (id_use_rt && (id_rt != '0) && pend_view[id_rt]) ||
                (id_wr_en && (id_addr_reg != '0) && pend_view[id_addr_reg]);
    full      = (cnt_view == CNT_W'(MAX_OUT));
    id_ready  = !rst && id_valid && !hazard && !(id_wr_en && id_long && full);
    issue_set = id_ready && id_wr_en && id_long && (id_addr_reg != '0);
    set_vec   = '0;
    if (issue_set) set_vec[id_addr_reg] = 1'b1;
  end

  // Clear is applied before set, so a bypassed same-register reissue leaves the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_mask <= '0;
      pend_cnt  <= '0;
      sb_err    <= 1'b0;
    end else begin
      pend_mask <= (pend_mask & ~wb_clr) | set_vec;
      pend_cnt  <= pend_cnt + CNT_W'(issue_set) - CNT_W'(wb_hit);
      if (wb_valid && !wb_hit) sb_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: directed scenarios, then random traffic vs a queue model.
module tb_id_scoreboard;
  localparam int ADR_W   = 5;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_use_rs, id_use_rt, id_wr_en, id_long, wb_valid;
  logic [ADR_W-1:0] id_rs, id_rt, id_addr_reg, wb_addr;
  logic id_ready;
  logic [31:0] pend_mask;
  logic [3:0] pend_cnt;
  logic sb_err;

  int checks = 0;
  int errors = 0;

  // Model: list of registers with an outstanding long write, plus the sticky error flag.
  int  outq[$];
  bit  m_err;

  id_scoreboard #(.ADR_W(ADR_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_addr_reg(id_addr_reg), .id_long(id_long), .id_ready(id_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .pend_mask(pend_mask),
    .pend_cnt(pend_cnt), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_pend(int r);
    foreach (outq[i]) if (outq[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_mask();
    logic [31:0] m = '0;
    foreach (outq[i]) m[outq[i]] = 1'b1;
    return m;
  endfunction

  function automatic bit wb_ok();
    return wb_valid && (int'(wb_addr) != 0) && is_pend(int'(wb_addr));
  endfunction

  // Pending as the issue check sees it (bypass removes the register being written back).
  function automatic bit seen_pend(int r);
    if (r == 0) return 1'b0;
`ifdef BLUEX_SB_WB_BYPASS_EN
    if (wb_ok() && r == int'(wb_addr)) return 1'b0;
`endif
    return is_pend(r);
  endfunction

  function automatic bit model_ready();
    int  n = outq.size();
    bit  haz;
`ifdef BLUEX_SB_WB_BYPASS_EN
    if (wb_ok()) n = n - 1;
`endif
    haz = (id_use_rs && seen_pend(int'(id_rs))) || (id_use_rt && seen_pend(int'(id_rt))) ||
          (id_wr_en && seen_pend(int'(id_addr_reg)));
    return id_valid && !haz && !(id_wr_en && id_long && n == MAX_OUT);
  endfunction

  task automatic model_update(input bit rdy);
    if (wb_ok()) begin
      foreach (outq[i]) if (outq[i] == int'(wb_addr)) begin outq.delete(i); break; end
    end else if (wb_valid) m_err = 1'b1;
    if (rdy && id_wr_en && id_long && int'(id_addr_reg) != 0) outq.push_back(int'(id_addr_reg));
  endtask

  task automatic drive(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                       input bit wr, input int ad, input bit lg, input bit wv, input int wa);
    id_valid = v;  id_rs = ADR_W'(rs); id_use_rs = urs; id_rt = ADR_W'(rt); id_use_rt = urt;
    id_wr_en = wr; id_addr_reg = ADR_W'(ad); id_long = lg; wb_valid = wv; wb_addr = ADR_W'(wa);
  endtask

  // One clock: check combinational ready, clock it, check registered state.
  task automatic step(input string tag);
    bit er;
    #1;
    er = model_ready();
    chk({tag, ".id_ready"}, 64'(id_ready), 64'(er));
    @(posedge clk);
    model_update(er);
    #1;
    chk({tag, ".pend_mask"}, 64'(pend_mask), 64'(exp_mask()));
    chk({tag, ".pend_cnt"}, 64'(pend_cnt), 64'(outq.size()));
    chk({tag, ".sb_err"}, 64'(sb_err), 64'(m_err));
  endtask

  initial begin
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_err = 1'b0;
    #12;
    chk("rst.id_ready", 64'(id_ready), 64'(0));
    chk("rst.pend_mask", 64'(pend_mask), 64'(0));
    chk("rst.pend_cnt", 64'(pend_cnt), 64'(0));
    chk("rst.sb_err", 64'(sb_err), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    step("idle_ready");

    // RAW on r8 until its write-back lands
    drive(1, 0, 0, 0, 0, 1, 8, 1, 0, 0);  step("t2.issue_r8");
    drive(1, 8, 1, 0, 0, 0, 0, 0, 0, 0);  step("t2.raw_stall");
    drive(1, 8, 1, 0, 0, 0, 0, 0, 1, 8);  step("t2.wb_cycle");
    drive(1, 8, 1, 0, 0, 0, 0, 0, 0, 0);  step("t2.after_wb");

    // Fill to MAX_OUT, then full blocks long writes only
    for (int r = 1; r <= 4; r++) begin
      drive(1, 0, 0, 0, 0, 1, r, 1, 0, 0); step("t3.fill");
    end
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);  step("t3.full_long");
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);  step("t3.full_short");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);  step("t3.wb_r2");
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);  step("t3.long_r5");
    chk("t3.cnt_full", 64'(pend_cnt), 64'(4));
    foreach (outq[i]) ;
    for (int r = 1; r <= 5; r++) if (r != 2) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, r); step("t3.drain");
    end

    // GPR 0 is never pending and never stalls
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);  step("t4.long_r0");
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);  step("t4.use_r0");

    // Write-back to a non-pending register is a sticky error
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 9);  step("t5.bad_wb");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step("t5.sticky");

    // Reset mid-stream drops pending state immediately
    drive(1, 0, 0, 0, 0, 1, 3, 1, 0, 0);  step("t6.r3");
    drive(1, 0, 0, 0, 0, 1, 7, 1, 0, 0);  step("t6.r7");
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b1; #1;
    outq.delete(); m_err = 1'b0;
    chk("t6.rst_mask", 64'(pend_mask), 64'(0));
    chk("t6.rst_cnt", 64'(pend_cnt), 64'(0));
    chk("t6.rst_ready", 64'(id_ready), 64'(0));
    chk("t6.rst_err", 64'(sb_err), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    step("t6.r3_user");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);  step("t6.lost_wb");

    // Random traffic on a small register window so hazards and fills are frequent
    for (int n = 0; n < 400; n++) begin
      int wa;
      bit wv = ($urandom % 10) < 4;
      if (outq.size() != 0 && ($urandom % 8) != 0) wa = outq[$urandom % outq.size()];
      else wa = int'($urandom % 8);
      drive(($urandom % 8) != 0, int'($urandom % 8), $urandom % 2 == 1,
            int'($urandom % 8), $urandom % 2 == 1, $urandom % 2 == 1,
            int'($urandom % 8), ($urandom % 10) < 6, wv, wa);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
